wb_stream_loader: RTL

//  Boot-image loader and Wishbone master that sits upstream of the SoC main memory (wb_bfm_memory).

---
 rtl/wb_stream_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stream_loader.sv
// wb_stream_loader
//   Boot-image loader and Wishbone master. Consumes a byte stream made of a
//   4-byte big-endian word count N followed by N big-endian 32-bit words, and
//   writes word i to BASE_ADR + 4*i over classic Wishbone. Keeps the CPU in
//   reset until the whole image has been written.
//
// Ports
//   wb_clk_i, wb_rst_n_i      clock, asynchronous active-low reset
//   start_i                   one-cycle pulse; (re)starts a load from IDLE/DONE/ERROR
//   s_data_i/s_valid_i        stream byte in
//   s_ready_o                 byte accepted when s_valid_i & s_ready_o
//   wb_adr_o..wb_bte_o        Wishbone master write port
//   wb_ack_i, wb_err_i        slave acknowledge / error
//   cpu_rst_o                 CPU reset request, low only once the image is done
//   done_o, err_o             load complete / load aborted

module wb_stream_loader #(
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 8192,
  parameter bit          AUTOSTART = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);

  // StIssue is the one-cycle gap between the 4th data byte and the bus request.
  typedef enum logic [2:0] {
    StIdle, StHdr, StData, StIssue, StWrite, StDone, StError
  } state_e;

  state_e          state;
  logic [1:0]      byte_cnt;
  logic [31:0]     shift;
  logic [31:0]     word_cnt;
  logic [IdxW-1:0] word_idx;

  logic            byte_fire;
  logic [31:0]     byte_word;
  logic [IdxW-1:0] idx_next;
  logic            last_word;

  assign byte_fire = s_valid_i & s_ready_o;
  assign byte_word = {shift[23:0], s_data_i};
  assign idx_next  = word_idx + IdxW'(1);
  assign last_word = (32'(idx_next) == word_cnt);

  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = wb_cyc_o;
  assign wb_sel_o = 4'hf;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= AUTOSTART ? StHdr : StIdle;
      byte_cnt  <= 2'd0;
      shift     <= 32'd0;
      word_cnt  <= 32'd0;
      word_idx  <= '0;
      s_ready_o <= 1'b0;
      wb_adr_o  <= BASE_ADR;
      wb_dat_o  <= 32'd0;
      wb_cyc_o  <= 1'b0;
      cpu_rst_o <= 1'b1;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          s_ready_o <= 1'b0;
          if (start_i) begin
            state     <= StHdr;
            s_ready_o <= 1'b1;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            cpu_rst_o <= 1'b1;
            byte_cnt  <= 2'd0;
            word_idx  <= '0;
          end
        end

        StHdr: begin
          // Also raises ready on the first cycle after an autostart reset.
          s_ready_o <= 1'b1;
          if (byte_fire) begin
            shift    <= byte_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_cnt <= byte_word;
              if (byte_word == 32'd0) begin
                state     <= StDone;
                s_ready_o <= 1'b0;
                done_o    <= 1'b1;
                cpu_rst_o <= 1'b0;
              end else if (byte_word > MAX_WORDS) begin
                state     <= StError;
                s_ready_o <= 1'b0;
                err_o     <= 1'b1;
              end else begin
                state <= StData;
              end
            end
          end
        end

        StData: begin
          if (byte_fire) begin
            shift    <= byte_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= StIssue;
              s_ready_o <= 1'b0;
            end
          end
        end

        StIssue: begin
          wb_dat_o <= shift;
          wb_adr_o <= BASE_ADR + (32'(word_idx) << 2);
          wb_cyc_o <= 1'b1;
          state    <= StWrite;
        end

        StWrite: begin
          // A slave error wins over a simultaneous ack.
          if (wb_err_i) begin
            wb_cyc_o <= 1'b0;
            err_o    <= 1'b1;
            state    <= StError;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            word_idx <= idx_next;
            if (last_word) begin
              state     <= StDone;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              state     <= StData;
              s_ready_o <= 1'b1;
            end
          end
        end

        StDone, StError: begin
          s_ready_o <= 1'b0;
          if (start_i) begin
            state     <= StHdr;
            s_ready_o <= 1'b1;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            cpu_rst_o <= 1'b1;
            byte_cnt  <= 2'd0;
            word_idx  <= '0;
          end
        end

        default: begin
          state     <= StIdle;
          s_ready_o <= 1'b0;
          wb_cyc_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
